dec_pipe: RTL and testbench



---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/decoder.sv | 107 ++++++++++
 rtl/ff_sel.sv | 28 ++
 rtl/dec_pipe.sv | 135 +++++++++++++
 tb/tb_dec_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: unit encodings, forwarding channel and decoded
// instruction fields.
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int NB_UNIT      = 2;
  localparam int NB_OPERATION = 4;

  localparam logic [NB_UNIT-1:0] UNIT_ALU = 2'd0;
  localparam logic [NB_UNIT-1:0] UNIT_LSU = 2'd1;
  localparam logic [NB_UNIT-1:0] UNIT_BRU = 2'd2;
  localparam logic [NB_UNIT-1:0] UNIT_CSR = 2'd3;

  typedef struct packed {
    logic            valid;
    logic            rdy;
    logic [4:0]      adr;
    logic [XLEN-1:0] data;
  } ff_chan_t;

  typedef struct packed {
    logic                    rs1_v;
    logic [4:0]              rs1_adr;
    logic                    rs2_v;
    logic [4:0]              rs2_adr;
    logic                    rd_v;
    logic [4:0]              rd_adr;
    logic                    csr_rd;
    logic                    csr_wbk;
    logic [11:0]             csr_adr;
    logic [XLEN-1:0]         imm;
    logic                    rs2_is_immediat;
    logic                    rs2_is_csr;
    logic                    auipc;
    logic                    unsign;
    logic                    csr_clear;
    logic                    rs2_ca2_v;
    logic [2:0]              access_size;
    logic                    unsign_ext;
    logic [NB_UNIT-1:0]      unit;
    logic [NB_OPERATION-1:0] operation;
  } dec_t;

endpackage

// File: rtl/decoder.sv
// Combinational RV32I/Zicsr field decoder feeding the decode stage.
module decoder
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_t            dec
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    dec.rs1_adr   = instr[19:15];
    dec.rs2_adr   = instr[24:20];
    dec.rd_adr    = instr[11:7];
    dec.operation = {1'b0, f3};
    case (opc)
      7'b0110011: begin
        dec.rs1_v     = 1'b1;
        dec.rs2_v     = 1'b1;
        dec.rd_v      = 1'b1;
        dec.operation = {instr[30], f3};
        dec.unsign    = (f3 == 3'b011);
        dec.rs2_ca2_v = ((f3 == 3'b000) && instr[30]) || (f3[2:1] == 2'b01);
      end
      7'b0010011: begin
        dec.rs1_v           = 1'b1;
        dec.rd_v            = 1'b1;
        dec.rs2_is_immediat = 1'b1;
        dec.imm             = i_imm;
        dec.operation       = {(f3 == 3'b101) && instr[30], f3};
        dec.unsign          = (f3 == 3'b011);
        dec.rs2_ca2_v       = (f3[2:1] == 2'b01);
      end
      7'b0110111, 7'b0010111: begin
        dec.rs1_adr         = 5'd0;
        dec.rd_v            = 1'b1;
        dec.rs2_is_immediat = 1'b1;
        dec.imm             = u_imm;
        dec.auipc           = opc[5] == 1'b0;
      end
      7'b0000011: begin
        dec.rs1_v           = 1'b1;
        dec.rd_v            = 1'b1;
        dec.rs2_is_immediat = 1'b1;
        dec.imm             = i_imm;
        dec.unit            = UNIT_LSU;
        dec.access_size     = {1'b0, f3[1:0]};
        dec.unsign_ext      = f3[2];
      end
      7'b0100011: begin
        dec.rs1_v       = 1'b1;
        dec.rs2_v       = 1'b1;
        dec.imm         = s_imm;
        dec.unit        = UNIT_LSU;
        dec.access_size = {1'b0, f3[1:0]};
      end
      7'b1100011: begin
        dec.rs1_v     = 1'b1;
        dec.rs2_v     = 1'b1;
        dec.imm       = b_imm;
        dec.unit      = UNIT_BRU;
        dec.unsign    = f3[1];
        dec.rs2_ca2_v = 1'b1;
      end
      7'b1101111: begin
        dec.rs1_adr = 5'd0;
        dec.rd_v    = 1'b1;
        dec.imm     = j_imm;
        dec.unit    = UNIT_BRU;
        dec.auipc   = 1'b1;
      end
      7'b1100111: begin
        dec.rs1_v = 1'b1;
        dec.rd_v  = 1'b1;
        dec.imm   = i_imm;
        dec.unit  = UNIT_BRU;
      end
      7'b1110011: begin
        if (f3 != 3'b000) begin
          // immediate CSR forms carry zimm in the rs1 field, so no register read
          dec.rs1_v      = ~f3[2];
          dec.rs1_adr    = f3[2] ? 5'd0 : instr[19:15];
          dec.rd_v       = 1'b1;
          dec.csr_rd     = 1'b1;
          dec.csr_wbk    = 1'b1;
          dec.csr_adr    = instr[31:20];
          dec.rs2_is_csr = 1'b1;
          dec.csr_clear  = (f3[1:0] == 2'b11);
          dec.unit       = UNIT_CSR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ff_sel.sv
// Priority matcher over forwarding channels; channel 0 (youngest) wins.
module ff_sel
  import riscv_pkg::*;
#(
  parameter int NB_FF = 2
) (
  input  logic                  src_v,
  input  logic [4:0]            src_adr,
  input  ff_chan_t [NB_FF-1:0]  ch,
  output logic                  hit,
  output logic                  rdy,
  output logic [XLEN-1:0]       data
);

  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int n = NB_FF - 1; n >= 0; n--) begin
      if (src_v && ch[n].valid && (ch[n].adr == src_adr) && (src_adr != 5'd0)) begin
        hit  = 1'b1;
        rdy  = ch[n].rdy;
        data = ch[n].data;
      end
    end
  end

endmodule

// File: rtl/dec_pipe.sv
// Decode stage: operand forwarding, hazard interlock, qualified operands and
// a single output register toward execute.
module dec_pipe #(
  parameter int XLEN  = 32,
  parameter int NB_FF = 2,
  parameter bit FF_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              if_valid_i,
  output logic                              if_ready_o,
  input  logic [XLEN-1:0]                   instr_i,
  input  logic [XLEN-1:0]                   pc_i,
  output logic [4:0]                        rfr_rs1_adr_o,
  output logic [4:0]                        rfr_rs2_adr_o,
  input  logic [XLEN-1:0]                   rf_rs1_data_i,
  input  logic [XLEN-1:0]                   rf_rs2_data_i,
  output logic [11:0]                       csr_adr_o,
  input  logic [XLEN-1:0]                   csr_data_i,
  input  logic [NB_FF-1:0]                  ff_valid_i,
  input  logic [NB_FF-1:0]                  ff_rdy_i,
  input  logic [5*NB_FF-1:0]                ff_rd_adr_i,
  input  logic [XLEN*NB_FF-1:0]             ff_data_i,
  input  logic                              flush_i,
  output logic                              exe_valid_o,
  input  logic                              exe_ready_i,
  output logic [XLEN-1:0]                   pc_q_o,
  output logic                              rd_v_q_o,
  output logic [4:0]                        rd_adr_q_o,
  output logic                              csr_wbk_q_o,
  output logic [11:0]                       csr_adr_q_o,
  output logic [XLEN:0]                     rs1_data_qual_q_o,
  output logic [XLEN:0]                     rs2_data_qual_q_o,
  output logic [XLEN-1:0]                   branch_imm_q_o,
  output logic [2:0]                        access_size_q_o,
  output logic                              unsign_ext_q_o,
  output logic [riscv_pkg::NB_UNIT-1:0]      unit_q_o,
  output logic [riscv_pkg::NB_OPERATION-1:0] operation_q_o,
  output logic [CNT_W-1:0]                  stall_cnt_o
);

  riscv_pkg::dec_t                 dec;
  riscv_pkg::ff_chan_t [NB_FF-1:0] ch;
  logic            s1_hit, s1_rdy, s2_hit, s2_rdy;
  logic [XLEN-1:0] s1_data, s2_data, rs1_raw, rs2_raw;
  logic [XLEN:0]   rs1_qual, rs2_ext, rs2_qual;
  logic            hazard, load, accept;

  decoder u_dec (.instr(instr_i), .dec(dec));

  assign rfr_rs1_adr_o = dec.rs1_adr;
  assign rfr_rs2_adr_o = dec.rs2_adr;
  assign csr_adr_o     = dec.csr_rd ? dec.csr_adr : 12'd0;

  always_comb begin
    for (int n = 0; n < NB_FF; n++) begin
      ch[n].valid = ff_valid_i[n];
      ch[n].rdy   = ff_rdy_i[n];
      ch[n].adr   = ff_rd_adr_i[5*n +: 5];
      ch[n].data  = ff_data_i[XLEN*n +: XLEN];
    end
  end

  ff_sel #(.NB_FF(NB_FF)) u_sel_rs1 (
    .src_v(dec.rs1_v), .src_adr(dec.rs1_adr), .ch(ch),
    .hit(s1_hit), .rdy(s1_rdy), .data(s1_data)
  );

  ff_sel #(.NB_FF(NB_FF)) u_sel_rs2 (
    .src_v(dec.rs2_v), .src_adr(dec.rs2_adr), .ch(ch),
    .hit(s2_hit), .rdy(s2_rdy), .data(s2_data)
  );

  // without forwarding any pending producer must retire through the RF first
  assign hazard = if_valid_i & ((s1_hit & (~s1_rdy | ~FF_EN)) |
                                (s2_hit & (~s2_rdy | ~FF_EN)));

  assign rs1_raw = ((s1_hit && FF_EN) ? s1_data : rf_rs1_data_i) |
                   (dec.auipc ? pc_i : '0);

  always_comb begin
    if (dec.rs2_is_immediat)   rs2_raw = dec.imm;
    else if (dec.rs2_is_csr)   rs2_raw = csr_data_i;
    else if (s2_hit && FF_EN)  rs2_raw = s2_data;
    else                       rs2_raw = rf_rs2_data_i;
  end

  assign rs1_qual = {~dec.unsign & rs1_raw[XLEN-1], dec.csr_clear ? ~rs1_raw : rs1_raw};
  assign rs2_ext  = {~dec.unsign & rs2_raw[XLEN-1], rs2_raw};
  assign rs2_qual = dec.rs2_ca2_v ? (~rs2_ext + 1'b1) : rs2_ext;

  assign load       = ~exe_valid_o | exe_ready_i;
  assign if_ready_o = ~reset & load & ~hazard & ~flush_i;
  assign accept     = if_valid_i & if_ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid_o       <= 1'b0;
      pc_q_o            <= '0;
      rd_v_q_o          <= 1'b0;
      rd_adr_q_o        <= '0;
      csr_wbk_q_o       <= 1'b0;
      csr_adr_q_o       <= '0;
      rs1_data_qual_q_o <= '0;
      rs2_data_qual_q_o <= '0;
      branch_imm_q_o    <= '0;
      access_size_q_o   <= '0;
      unsign_ext_q_o    <= 1'b0;
      unit_q_o          <= '0;
      operation_q_o     <= '0;
      stall_cnt_o       <= '0;
    end else begin
      if (flush_i)   exe_valid_o <= 1'b0;
      else if (load) exe_valid_o <= accept;
      if (accept) begin
        pc_q_o            <= pc_i;
        rd_v_q_o          <= dec.rd_v;
        rd_adr_q_o        <= dec.rd_adr;
        csr_wbk_q_o       <= dec.csr_wbk;
        csr_adr_q_o       <= dec.csr_adr;
        rs1_data_qual_q_o <= rs1_qual;
        rs2_data_qual_q_o <= rs2_qual;
        branch_imm_q_o    <= dec.imm;
        access_size_q_o   <= dec.access_size;
        unsign_ext_q_o    <= dec.unsign_ext;
        unit_q_o          <= dec.unit;
        operation_q_o     <= dec.operation;
      end
      if (hazard && !flush_i && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_dec_pipe.sv
// Directed bench for dec_pipe: a forwarding instance and a no-forwarding
// instance with a narrow stall counter.
module tb_dec_pipe;

  localparam int XLEN  = 32;
  localparam int NB_FF = 2;

  localparam logic [31:0] I_ADD    = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADD_X0 = 32'h002001B3; // add  x3,x0,x2
  localparam logic [31:0] I_SUB    = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_SLTU   = 32'h0020B1B3; // sltu x3,x1,x2
  localparam logic [31:0] I_CSRRC  = 32'h3000B2F3; // csrrc x5,0x300,x1

  logic clk = 1'b0;
  logic reset;
  logic if_valid, nf_valid, flush, exe_ready;
  logic [XLEN-1:0] instr, pc, rf1, rf2, csr_data;
  logic [NB_FF-1:0] ff_valid, ff_rdy;
  logic [5*NB_FF-1:0] ff_adr;
  logic [XLEN*NB_FF-1:0] ff_data;

  logic m_if_ready, m_exe_valid, m_rd_v, m_csr_wbk, m_uext;
  logic [4:0] m_rs1_adr, m_rs2_adr, m_rd_adr;
  logic [11:0] m_csr_adr, m_csr_adr_q;
  logic [XLEN-1:0] m_pc_q, m_imm;
  logic [XLEN:0] m_rs1q, m_rs2q;
  logic [2:0] m_size;
  logic [1:0] m_unit;
  logic [3:0] m_op;
  logic [15:0] m_cnt;

  logic n_if_ready, n_exe_valid, n_rd_v, n_csr_wbk, n_uext;
  logic [4:0] n_rs1_adr, n_rs2_adr, n_rd_adr;
  logic [11:0] n_csr_adr, n_csr_adr_q;
  logic [XLEN-1:0] n_pc_q, n_imm;
  logic [XLEN:0] n_rs1q, n_rs2q;
  logic [2:0] n_size;
  logic [1:0] n_unit;
  logic [3:0] n_op;
  logic [3:0] n_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec_pipe #(.XLEN(XLEN), .NB_FF(NB_FF), .FF_EN(1'b1), .CNT_W(16)) u_main (
    .clk(clk), .reset(reset), .if_valid_i(if_valid), .if_ready_o(m_if_ready),
    .instr_i(instr), .pc_i(pc), .rfr_rs1_adr_o(m_rs1_adr), .rfr_rs2_adr_o(m_rs2_adr),
    .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .csr_adr_o(m_csr_adr), .csr_data_i(csr_data),
    .ff_valid_i(ff_valid), .ff_rdy_i(ff_rdy), .ff_rd_adr_i(ff_adr), .ff_data_i(ff_data),
    .flush_i(flush), .exe_valid_o(m_exe_valid), .exe_ready_i(exe_ready), .pc_q_o(m_pc_q),
    .rd_v_q_o(m_rd_v), .rd_adr_q_o(m_rd_adr), .csr_wbk_q_o(m_csr_wbk), .csr_adr_q_o(m_csr_adr_q),
    .rs1_data_qual_q_o(m_rs1q), .rs2_data_qual_q_o(m_rs2q), .branch_imm_q_o(m_imm),
    .access_size_q_o(m_size), .unsign_ext_q_o(m_uext), .unit_q_o(m_unit),
    .operation_q_o(m_op), .stall_cnt_o(m_cnt)
  );

  dec_pipe #(.XLEN(XLEN), .NB_FF(NB_FF), .FF_EN(1'b0), .CNT_W(4)) u_nf (
    .clk(clk), .reset(reset), .if_valid_i(nf_valid), .if_ready_o(n_if_ready),
    .instr_i(instr), .pc_i(pc), .rfr_rs1_adr_o(n_rs1_adr), .rfr_rs2_adr_o(n_rs2_adr),
    .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .csr_adr_o(n_csr_adr), .csr_data_i(csr_data),
    .ff_valid_i(ff_valid), .ff_rdy_i(ff_rdy), .ff_rd_adr_i(ff_adr), .ff_data_i(ff_data),
    .flush_i(flush), .exe_valid_o(n_exe_valid), .exe_ready_i(exe_ready), .pc_q_o(n_pc_q),
    .rd_v_q_o(n_rd_v), .rd_adr_q_o(n_rd_adr), .csr_wbk_q_o(n_csr_wbk), .csr_adr_q_o(n_csr_adr_q),
    .rs1_data_qual_q_o(n_rs1q), .rs2_data_qual_q_o(n_rs2q), .branch_imm_q_o(n_imm),
    .access_size_q_o(n_size), .unsign_ext_q_o(n_uext), .unit_q_o(n_unit),
    .operation_q_o(n_op), .stall_cnt_o(n_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ff(input int n, input logic v, input logic r,
                        input logic [4:0] a, input logic [XLEN-1:0] d);
    ff_valid[n] = v;
    ff_rdy[n] = r;
    ff_adr[5*n +: 5] = a;
    ff_data[XLEN*n +: XLEN] = d;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; nf_valid = 1'b0; flush = 1'b0; exe_ready = 1'b1;
    instr = '0; pc = '0; rf1 = '0; rf2 = '0; csr_data = '0;
    ff_valid = '0; ff_rdy = '0; ff_adr = '0; ff_data = '0;
    tick();
    chk("rst_exe_valid", m_exe_valid, 0);
    chk("rst_if_ready", m_if_ready, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_rs1q", m_rs1q, 0);
    chk("rst_csr_adr", m_csr_adr, 0);
    reset = 1'b0; #1;
    chk("idle_if_ready", m_if_ready, 1);

    // both channels hold x1; channel 0 must win
    instr = I_ADD; pc = 32'h100; rf1 = 5; rf2 = 3; if_valid = 1'b1;
    set_ff(0, 1, 1, 5'd1, 32'h10); set_ff(1, 1, 1, 5'd1, 32'h20); #1;
    chk("fwd_if_ready", m_if_ready, 1);
    chk("fwd_csr_adr", m_csr_adr, 0);
    chk("fwd_rfr_rs1", m_rs1_adr, 1);
    tick();
    chk("fwd_exe_valid", m_exe_valid, 1);
    chk("fwd_rs1q", m_rs1q, 33'h0_00000010);
    chk("fwd_rs2q", m_rs2q, 33'h0_00000003);
    chk("fwd_pc", m_pc_q, 32'h100);
    chk("fwd_rd_adr", m_rd_adr, 3);

    // load-use: producer not ready for three cycles
    pc = 32'h104; set_ff(0, 1, 0, 5'd1, 32'h7); set_ff(1, 0, 0, 5'd0, 32'h0); #1;
    for (int k = 0; k < 3; k++) begin
      chk("lu_if_ready", m_if_ready, 0);
      tick();
    end
    chk("lu_drain", m_exe_valid, 0);
    chk("lu_cnt", m_cnt, 3);
    ff_rdy[0] = 1'b1; #1;
    chk("lu_ready", m_if_ready, 1);
    tick();
    chk("lu_rs1q", m_rs1q, 33'h0_00000007);
    chk("lu_exe_valid", m_exe_valid, 1);
    chk("lu_cnt_hold", m_cnt, 3);
    chk("lu_pc", m_pc_q, 32'h104);

    // x0 never matches a channel
    instr = I_ADD_X0; rf1 = 0; pc = 32'h108; set_ff(0, 1, 1, 5'd0, 32'hFF); #1;
    chk("x0_if_ready", m_if_ready, 1);
    tick();
    chk("x0_rs1q", m_rs1q, 0);
    chk("x0_cnt", m_cnt, 3);

    // no-forwarding instance stalls on a ready match until it drops
    if_valid = 1'b0; instr = I_ADD; rf1 = 9; set_ff(0, 1, 1, 5'd1, 32'h55); nf_valid = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      chk("nf_if_ready", n_if_ready, 0);
      tick();
    end
    ff_valid[0] = 1'b0; #1;
    chk("nf_ready", n_if_ready, 1);
    tick();
    chk("nf_rs1q", n_rs1q, 33'h0_00000009);
    chk("nf_exe_valid", n_exe_valid, 1);
    chk("nf_cnt", n_cnt, 2);
    chk("main_idle_cnt", m_cnt, 3);
    nf_valid = 1'b0;

    instr = I_SUB; rf1 = 10; rf2 = 1; pc = 32'h200; ff_valid = '0; if_valid = 1'b1; #1;
    tick();
    chk("sub_rs2q", m_rs2q, 33'h1_FFFFFFFF);
    chk("sub_rs1q", m_rs1q, 33'h0_0000000A);

    // backpressure holds payload and blocks the next instruction
    exe_ready = 1'b0; instr = I_SLTU; rf1 = 32'h80000000; rf2 = 1; pc = 32'h204; #1;
    for (int k = 0; k < 2; k++) begin
      chk("bp_if_ready", m_if_ready, 0);
      tick();
      chk("bp_pc", m_pc_q, 32'h200);
      chk("bp_valid", m_exe_valid, 1);
    end
    exe_ready = 1'b1; #1;
    chk("bp_release", m_if_ready, 1);
    tick();
    chk("sltu_rs1q", m_rs1q, 33'h0_80000000);
    chk("sltu_rs2q", m_rs2q, 33'h1_FFFFFFFF);
    chk("sltu_pc", m_pc_q, 32'h204);

    instr = I_ADD; rf1 = 32'h80000000; rf2 = 0; pc = 32'h208; #1;
    tick();
    chk("add_sign_rs1q", m_rs1q, 33'h1_80000000);

    instr = I_CSRRC; rf1 = 32'hF; csr_data = 32'h12345678; pc = 32'h20C; #1;
    chk("csr_adr_comb", m_csr_adr, 12'h300);
    tick();
    chk("csr_rs1q", m_rs1q, 33'h0_FFFFFFF0);
    chk("csr_rs2q", m_rs2q, 33'h0_12345678);
    chk("csr_adr_q", m_csr_adr_q, 12'h300);
    chk("csr_wbk", m_csr_wbk, 1);

    // flush with a pending hazard: no accept, no stall count
    instr = I_ADD; pc = 32'h210; set_ff(0, 1, 0, 5'd1, 32'h0); flush = 1'b1; #1;
    chk("fl_if_ready", m_if_ready, 0);
    tick();
    chk("fl_exe_valid", m_exe_valid, 0);
    chk("fl_cnt", m_cnt, 3);
    chk("fl_pc", m_pc_q, 32'h20C);
    flush = 1'b0;

    // 4-bit counter on the no-forwarding instance: 2^4+5 hazard cycles
    if_valid = 1'b0; set_ff(0, 1, 1, 5'd1, 32'h0); nf_valid = 1'b1;
    repeat (21) tick();
    chk("nf_sat", n_cnt, 4'hF);
    nf_valid = 1'b0;

    // reset in the middle of a stall
    set_ff(0, 0, 0, 5'd0, 32'h0); instr = I_ADD; pc = 32'h300; rf1 = 1; if_valid = 1'b1; #1;
    tick();
    exe_ready = 1'b0; set_ff(0, 1, 0, 5'd1, 32'h0);
    tick();
    chk("pre_rst_cnt", m_cnt, 4);
    chk("pre_rst_valid", m_exe_valid, 1);
    #2;
    reset = 1'b1; instr = '0; #1;
    chk("mrst_exe_valid", m_exe_valid, 0);
    chk("mrst_cnt", m_cnt, 0);
    chk("mrst_pc", m_pc_q, 0);
    chk("mrst_rs1q", m_rs1q, 0);
    chk("mrst_if_ready", m_if_ready, 0);
    chk("mrst_csr_adr", m_csr_adr, 0);
    chk("mrst_nf_cnt", n_cnt, 0);
    tick();
    reset = 1'b0; if_valid = 1'b0; exe_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
